// File: rtl/pipeline_egress_pkg.sv
// Shared types/helpers for the pipeline egress buffer.
// Holds width helpers, parameter checks and default stitch latency.
package pipeline_egress_pkg;

  localparam int STITCH_LATENCY = 2;

  // Width of a counter that must hold values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic bit params_legal(
    input int lat,
    input int dep
  );
    return (lat >= 1) && (dep >= 1);
  endfunction

endpackage

// File: rtl/pipeline_egress_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, rst, push/wdata, pop/rdata, count, full, empty.
module pipeline_egress_fifo
  import pipeline_egress_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int CW        = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr;
  logic [AW-1:0]         r_rd;
  logic [CW-1:0]         r_cnt;

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wr <= nxt(r_wr);
      if (pop)  r_rd <= nxt(r_rd);
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign rdata = r_mem[r_rd];
  assign count = r_cnt;
  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);

endmodule

// File: rtl/pipeline_egress_buffer.sv
// Flow control around a fixed-latency stitched pipeline.
// Ports: clk, rst, in_valid/in_ready, pipe_out, out_valid/out_data/out_ready, occupancy.
module pipeline_egress_buffer
  import pipeline_egress_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = STITCH_LATENCY,
  parameter int DEPTH      = 4,
  localparam int CW        = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] pipe_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CW-1:0]         occupancy
);

  localparam int IW = cnt_w(LATENCY);
  localparam int SW = cnt_w(DEPTH + LATENCY);

  if (!params_legal(LATENCY, DEPTH)) begin : g_bad_params
    $error("pipeline_egress_buffer: LATENCY and DEPTH must be >= 1");
  end

  logic [LATENCY-1:0] r_vld;
  logic [IW-1:0]      w_inflight;
  logic [SW-1:0]      w_total;
  logic [CW-1:0]      w_count;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;

  assign w_accept = in_valid && in_ready;

  // Bit i set means the word on the pipeline's stage i is real.
  always_ff @(posedge clk) begin
    if (rst) r_vld <= '0;
    else     r_vld <= LATENCY'({r_vld, w_accept});
  end

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + IW'(r_vld[i]);
    end
  end

  // Credit covers stored plus in-flight words; state-only path.
  assign w_total  = SW'(w_count) + SW'(w_inflight);
  assign in_ready = (w_total < SW'(DEPTH));

  assign w_push = r_vld[LATENCY-1];
  assign w_pop  = out_valid && out_ready;

  pipeline_egress_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (pipe_out),
    .pop   (w_pop),
    .rdata (out_data),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign occupancy = w_count;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst) !(w_push && w_full)
  );

endmodule

// File: tb/tb_pipeline_egress_buffer.sv
// Directed bench for pipeline_egress_buffer.
// Two instances: L=2/D=4 directed tests, L=1/D=3 randomized scoreboard.
module tb_pipeline_egress_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_pin, a_p1, a_p2, a_od;
  logic [2:0]  a_occ;
  logic        b_iv, b_ir, b_ov, b_or;
  logic [31:0] b_pin, b_p1, b_od;
  logic [1:0]  b_occ;

  // Stitched pipelines: plain delay lines, never reset.
  always_ff @(posedge clk) begin
    a_p1 <= a_pin;
    a_p2 <= a_p1;
    b_p1 <= b_pin;
  end

  pipeline_egress_buffer #(
    .DATA_WIDTH (32),
    .LATENCY    (2),
    .DEPTH      (4)
  ) u_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_iv),
    .in_ready  (a_ir),
    .pipe_out  (a_p2),
    .out_valid (a_ov),
    .out_data  (a_od),
    .out_ready (a_or),
    .occupancy (a_occ)
  );

  pipeline_egress_buffer #(
    .DATA_WIDTH (32),
    .LATENCY    (1),
    .DEPTH      (3)
  ) u_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_iv),
    .in_ready  (b_ir),
    .pipe_out  (b_p1),
    .out_valid (b_ov),
    .out_data  (b_od),
    .out_ready (b_or),
    .occupancy (b_occ)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int nw, ex, got, gaps, acc, last;
  int first_acc, last_acc, first_out;
  int fp, occmax, beats;

  initial begin
    rst   = 1'b1;
    a_iv  = 1'b1;
    a_or  = 1'b0;
    a_pin = '0;
    b_iv  = 1'b0;
    b_or  = 1'b0;
    b_pin = '0;
    tick();
    tick();
    rst  = 1'b0;
    a_iv = 1'b0;
    chk("rst_in_ready", 32'(a_ir), 1);
    chk("rst_out_valid", 32'(a_ov), 0);
    chk("rst_occ", 32'(a_occ), 0);
    chk("rst_b_occ", 32'(b_occ), 0);

    // Streaming 1..20
    nw = 1; ex = 1; got = 0; gaps = 0;
    first_acc = -1; last_acc = -1; first_out = -1;
    a_or = 1'b1;
    for (int c = 0; c < 40; c++) begin
      a_iv  = (nw <= 20);
      a_pin = 32'(nw);
      if (a_iv && a_ir) begin
        if (first_acc < 0) first_acc = c;
        last_acc = c;
        nw++;
      end
      if (a_ov) begin
        chk("stream_data", a_od, 32'(ex));
        ex++;
        got++;
        if (first_out < 0) first_out = c;
      end else if (first_out >= 0 && got < 20) begin
        gaps++;
      end
      tick();
    end
    a_iv = 1'b0;
    chk("stream_accepts", 32'(nw - 1), 20);
    chk("stream_b2b", 32'(last_acc - first_acc), 19);
    chk("stream_latency", 32'(first_out - first_acc), 3);
    chk("stream_count", 32'(got), 20);
    chk("stream_gaps", 32'(gaps), 0);

    // Backpressure
    a_or = 1'b0;
    nw = 101; acc = 0; last = -1; occmax = 0;
    for (int c = 0; c < 12; c++) begin
      a_iv  = 1'b1;
      a_pin = 32'(nw);
      if (int'(a_occ) > occmax) occmax = int'(a_occ);
      if (a_iv && a_ir) begin
        acc++;
        last = c;
        nw++;
      end
      tick();
    end
    a_iv = 1'b0;
    chk("bp_accepts", 32'(acc), 4);
    chk("bp_last_accept", 32'(last), 3);
    chk("bp_in_ready", 32'(a_ir), 0);
    chk("bp_occ", 32'(a_occ), 4);
    chk("bp_occ_max", 32'(occmax), 4);
    chk("bp_out_valid", 32'(a_ov), 1);

    a_or = 1'b1;
    ex = 101; got = 0; fp = -1;
    for (int c = 0; c < 10; c++) begin
      if (fp >= 0 && c == fp + 1) chk("bp_ready_after_pop", 32'(a_ir), 1);
      if (a_ov) begin
        if (fp < 0) begin
          fp = c;
          chk("bp_ready_at_pop", 32'(a_ir), 0);
        end
        chk("bp_drain_data", a_od, 32'(ex));
        ex++;
        got++;
      end
      tick();
    end
    chk("bp_drain_count", 32'(got), 4);

    // Sparse input with garbage between
    got = 0;
    for (int c = 0; c < 20; c++) begin
      a_iv  = (c == 0 || c == 4);
      a_pin = (c == 0) ? 32'hA5 : (c == 4) ? 32'h5A : 32'hDEAD_0000 + 32'(c);
      if (a_iv) chk("sparse_ready", 32'(a_ir), 1);
      if (a_ov) begin
        chk("sparse_data", a_od, (got == 0) ? 32'hA5 : 32'h5A);
        got++;
      end
      tick();
    end
    a_iv = 1'b0;
    chk("sparse_beats", 32'(got), 2);

    // Reset with one stored and two in flight
    a_or = 1'b0;
    for (int c = 0; c < 3; c++) begin
      a_iv  = 1'b1;
      a_pin = 32'h300 + 32'(c);
      tick();
    end
    a_iv  = 1'b0;
    a_pin = 32'hBAD0;
    chk("mid_pre_occ", 32'(a_occ), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_occ", 32'(a_occ), 0);
    chk("mid_ready", 32'(a_ir), 1);
    a_or = 1'b1;
    beats = 0;
    for (int c = 0; c < 10; c++) begin
      a_pin = 32'hBAD0 + 32'(c);
      if (a_ov) beats++;
      tick();
    end
    chk("mid_no_valid", 32'(beats), 0);

    // Random traffic, DEPTH=3, LATENCY=1
    nw = 1; ex = 1; occmax = 0;
    for (int c = 0; c < 1000; c++) begin
      b_iv  = 1'($urandom_range(0, 1));
      b_or  = 1'($urandom_range(0, 1));
      b_pin = 32'(nw);
      if (int'(b_occ) > occmax) occmax = int'(b_occ);
      if (b_iv && b_ir) nw++;
      if (b_ov && b_or) begin
        chk("rand_data", b_od, 32'(ex));
        ex++;
      end
      tick();
    end
    b_iv = 1'b0;
    b_or = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (b_ov) begin
        chk("rand_drain", b_od, 32'(ex));
        ex++;
      end
      tick();
    end
    chk("rand_all_out", 32'(ex), 32'(nw));
    chk("rand_occ_max", 32'(occmax), 3);
    chk("rand_wrap", 32'(nw > 10), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_egress_buffer.md
Name: pipeline_egress_buffer

Overview:
Downstream companion to a stitched fixed-latency pipeline (e.g. a 2-stage `foo`). The stitched pipeline has no valid, ready or stall. This block adds the flow control around it:
- tracks which cycles carried real work into the pipeline;
- captures the pipeline output exactly LATENCY cycles later into a small FIFO;
- exposes a valid/ready interface to the consumer;
- throttles the producer with credits so the FIFO can never overflow.

Parameters:
- DATA_WIDTH, 32: width of the pipeline output word.
- LATENCY, 2: register stages between pipeline input and output; legal range ≥1.
- DEPTH, 4: FIFO entries; legal range ≥1. Full throughput needs DEPTH ≥ LATENCY+2.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: producer presents a word to the pipeline input this cycle.
- in_ready, output, 1: block has credit; the word is accepted when in_valid && in_ready.
- pipe_out, input, DATA_WIDTH: output port of the stitched pipeline.
- out_valid, output, 1: FIFO head is valid.
- out_data, output, DATA_WIDTH: FIFO head word.
- out_ready, input, 1: consumer accepts the head when out_valid && out_ready.
- occupancy, output, $clog2(DEPTH+1): FIFO entries held (excludes in-flight).

Behaviour:
- Reset: synchronous and active-high, on rst sampled high at a clk edge. Next cycle:
  - in_ready=1, out_valid=0, occupancy=0;
  - shift register vld[LATENCY-1:0]=0;
  - FIFO pointers and count = 0.
- Reset mid-operation: all in-flight and stored words are discarded. The pipeline itself is not reset; its stale output emerges but is ignored because vld is clear.
- accept = in_valid && in_ready.
- Valid shift register, each edge:
  - vld[0] <= accept;
  - vld[i] <= vld[i-1].
- Capture timing: a word accepted in cycle t appears on pipe_out in cycle t+LATENCY. In that cycle vld[LATENCY-1]=1, and pipe_out is written to the FIFO at the closing edge.
- inflight = popcount(vld), width $clog2(LATENCY+1).
- in_ready = (count + inflight) < DEPTH.
  - Registered-state only; no combinational path from out_ready or in_valid.
  - Invariant: count + inflight ≤ DEPTH at all times. A push into a full FIFO is therefore impossible; the implementation carries an assertion for it.
- FIFO behaviour:
  - first-word-fall-through; out_valid = (count != 0); out_data = mem[rd_ptr];
  - out_data is don't-care while out_valid=0; the bench must not check it then.
  - Write lands at the edge; the word is visible on out_data the following cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pop while empty: cannot occur, since pop requires out_valid.
- Pointers wrap modulo DEPTH; non-power-of-two DEPTH must work via an explicit compare-and-clear, not bit truncation.
- Backpressure: when out_ready is held low, at most DEPTH words are accepted in total. in_ready drops in the cycle where count+inflight reaches DEPTH.
- Throughput:
  - with out_ready=1 continuously and DEPTH ≥ LATENCY+2, one word per cycle is sustained;
  - minimum in_valid-to-out_valid latency is LATENCY+1 cycles.

Decomposition:
- Package pipeline_egress_pkg:
  - a count typedef helper and a parameter-legality check function (LATENCY≥1, DEPTH≥1);
  - the shared localparam for the default latency of generated stitched pipelines.
- One sub-module: pipeline_egress_fifo. Synchronous FWFT FIFO with push, pop, data, count and full/empty, parameterised by DATA_WIDTH and DEPTH, using the same clk/rst.
- The top block holds the vld shift register, inflight popcount and credit logic.

Test Plan:
- Reset check: hold rst for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, occupancy=0 in the first post-reset cycle.
- Streaming (LATENCY=2, DEPTH=4): in_valid=1 every cycle, out_ready=1, pipe_out modelled as a 2-cycle delay of counter input 1..20 → out_data yields 1..20 in order, first out_valid 3 cycles after the first accept, no gaps.
- Backpressure: out_ready=0 with in_valid=1 continuously → exactly 4 accepts; in_ready low from then on; occupancy reaches 4 and stays there. Then set out_ready=1 → words drain in order and in_ready reasserts the cycle after the first pop.
- Sparse input: accept words 0xA5 and 0x5A with a 3-cycle gap → exactly two out_valid beats carrying those values. Garbage driven on pipe_out in the other cycles is never captured.
- Reset mid-flight: accept 3 words, assert rst while 2 are in-flight → after reset occupancy=0, out_valid stays 0 for 10 cycles despite pipe_out activity.
- Non-power-of-two DEPTH=3, LATENCY=1: random in_valid/out_ready for 1000 cycles → scoreboard matches, occupancy never exceeds 3, pointer wrap is exercised.
